// File: rtl/hdr_collector_pkg.sv
// Shared types for the header collector: byte/header geometry, FSM states, header array.
// BYTE_BUS / HDR_MAX_LEN / TRUE / FALSE default here when def.svh has not already defined them.
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 16
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif
`ifndef FALSE
`define FALSE 1'b0
`endif

package hdr_collector_pkg;
    localparam int BYTE_W  = `BYTE_BUS;
    localparam int HDR_LEN = `HDR_MAX_LEN;
    localparam int LEN_W   = 8;
    localparam int IDX_W   = $clog2(HDR_LEN);

    typedef logic [HDR_LEN-1:0][BYTE_W-1:0] hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        WAIT,
        OUT
    } state_t;
endpackage

// File: rtl/hdr_collect_buf.sv
// Header byte buffer with saturating write count and truncation flag.
module hdr_collect_buf
    import hdr_collector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              first,
    input  logic              wr,
    input  logic              trunc_clr,
    input  logic [BYTE_W-1:0] data,
    output hdr_t              hdr,
    output logic [LEN_W-1:0]  count,
    output logic              trunc
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(HDR_LEN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr   <= '0;
            count <= '0;
            trunc <= 1'b0;
        end else begin
            if (first) begin
                // A new packet wipes leftovers so short headers read back zero-padded.
                hdr    <= '0;
                hdr[0] <= data;
                count  <= LEN_W'(1);
                trunc  <= 1'b0;
            end else if (wr) begin
                if (count < LEN_MAX) begin
                    hdr[count[IDX_W-1:0]] <= data;
                    count                 <= count + LEN_W'(1);
                end else begin
                    trunc <= 1'b1;
                end
            end
            if (trunc_clr)
                trunc <= 1'b0;
        end
    end
endmodule

// File: rtl/hdr_collector.sv
// Header collector: byte-stream ingress, processor start/wait handshake, held result.
// Optional processor watchdog enabled by defining HDR_COLLECT_TIMEOUT_EN.
module hdr_collector
    import hdr_collector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              proc_start_o,
    output hdr_t              proc_hdr_o,
    input  logic              proc_ready_i,
    input  hdr_t              proc_hdr_i,
    output logic              out_valid_o,
    output hdr_t              out_hdr_o,
    output logic [LEN_W-1:0]  out_len_o,
    output logic              out_trunc_o,
    input  logic              out_ack_i,
    output logic              err_o
);
    state_t           state, state_nxt;
    logic             guard;
    logic             accept;
    logic             capture;
    logic             timeout;
    logic             ack;
    logic [LEN_W-1:0] count;
    logic             trunc;
    hdr_t             buf_hdr;

    assign in_ready_o   = !rst && (state == IDLE || state == COLLECT);
    assign accept       = in_valid_i && in_ready_o;
    // Processor ready is stale during the first WAIT cycle; guard masks it.
    assign capture      = (state == WAIT) && !guard && proc_ready_i;
    assign ack          = (state == OUT) && out_ack_i;
    assign proc_start_o = (state == START);
    assign proc_hdr_o   = buf_hdr;
    assign out_len_o    = count;
    assign out_trunc_o  = trunc;

    hdr_collect_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .first     (accept && state == IDLE),
        .wr        (accept && state == COLLECT),
        .trunc_clr (ack),
        .data      (in_data_i),
        .hdr       (buf_hdr),
        .count     (count),
        .trunc     (trunc)
    );

`ifdef HDR_COLLECT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt <= '0;
        else if (state == START)
            to_cnt <= '0;
        else if (state == WAIT)
            to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout = (state == WAIT) && !capture && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_last_i ? START : COLLECT;
            COLLECT: if (accept && in_last_i) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (capture)
                    state_nxt = OUT;
                else if (timeout)
                    state_nxt = IDLE;
            end
            OUT:     if (out_ack_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            guard       <= 1'b0;
            out_valid_o <= 1'b0;
            out_hdr_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            guard <= (state == START);
            err_o <= timeout;
            if (capture) begin
                out_valid_o <= 1'b1;
                out_hdr_o   <= proc_hdr_i;
            end else if (ack) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hdr_collector.sv
// Directed self-checking bench for hdr_collector (timeout scenario runs when HDR_COLLECT_TIMEOUT_EN is defined).
module tb_hdr_collector;
    import hdr_collector_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [BYTE_W-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             proc_start;
    hdr_t             proc_hdr_o;
    logic             proc_ready;
    hdr_t             proc_hdr_i;
    logic             out_valid;
    hdr_t             out_hdr;
    logic [LEN_W-1:0] out_len;
    logic             out_trunc;
    logic             out_ack;
    logic             err;

    int n_cmp = 0;
    int n_err = 0;

    hdr_collector #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .proc_start_o (proc_start),
        .proc_hdr_o   (proc_hdr_o),
        .proc_ready_i (proc_ready),
        .proc_hdr_i   (proc_hdr_i),
        .out_valid_o  (out_valid),
        .out_hdr_o    (out_hdr),
        .out_len_o    (out_len),
        .out_trunc_o  (out_trunc),
        .out_ack_i    (out_ack),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bounded wait for out_valid; returns cycles waited (max+1 when expired).
    task automatic wait_valid(input int max, output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles <= max) begin
            tick();
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ack_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_data = '0; in_last = 0;
        proc_ready = 0; proc_hdr_i = '0; out_ack = 0;
        #3;
        n_cmp++;
        if ({in_ready, proc_start, out_valid, out_trunc, err} !== 5'b0 || out_len !== '0 ||
            proc_hdr_o !== '0 || out_hdr !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b st=%b v=%b len=%0d hdr=%h required all 0",
                     in_ready, proc_start, out_valid, out_len, proc_hdr_o);
        end
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        hdr_t exp_in, exp_out;
        int   starts;
        exp_in = '0;
        exp_in[0] = 8'h11; exp_in[1] = 8'h22; exp_in[2] = 8'h33; exp_in[3] = 8'h44;
        exp_out = exp_in;
        exp_out[0] = 8'hAA;
        proc_hdr_i = exp_out;
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 1);
        @(negedge clk);
        n_cmp++;
        if (proc_start !== 1'b1 || proc_hdr_o !== exp_in) begin
            n_err++;
            $display("FAIL basic_start: start=%b hdr=%h required 1 / %h", proc_start, proc_hdr_o, exp_in);
        end
        starts = 1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 5) proc_ready = 1'b1;
            @(negedge clk);
            if (proc_start === 1'b1) starts++;
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early_valid: out_valid=%b required 0", out_valid);
        end
        tick();
        proc_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_hdr !== exp_out || out_len !== 8'd4 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: v=%b hdr=%h len=%0d tr=%b required 1 / %h / 4 / 0",
                     out_valid, out_hdr, out_len, out_trunc, exp_out);
        end
        n_cmp++;
        if (starts !== 1) begin
            n_err++;
            $display("FAIL basic_start_count: got %0d pulses required 1", starts);
        end
        do_ack();
    endtask

    task automatic test_stale_ready();
        hdr_t junk, fresh;
        junk = '0;  junk[0] = 8'hEE; junk[5] = 8'hEE;
        fresh = '0; fresh[0] = 8'h3C; fresh[1] = 8'h01;
        proc_hdr_i = junk;
        proc_ready = 1'b1;
        send_byte(8'h3C, 1);
        @(negedge clk);
        n_cmp++;
        if (proc_start !== 1'b1) begin
            n_err++;
            $display("FAIL stale_start: start=%b required 1", proc_start);
        end
        tick();               // first WAIT cycle with stale ready still high
        tick();
        proc_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_guard: out_valid=%b required 0", out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stale_idle_wait: cycle %0d out_valid=%b required 0", c, out_valid);
            end
        end
        proc_hdr_i = fresh;
        proc_ready = 1'b1;
        tick();
        proc_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_hdr !== fresh || out_len !== 8'd1) begin
            n_err++;
            $display("FAIL stale_capture: v=%b hdr=%h len=%0d required 1 / %h / 1", out_valid, out_hdr, out_len, fresh);
        end
        do_ack();
    endtask

    task automatic test_trunc();
        hdr_t exp_in, exp_out;
        int   cyc;
        for (int i = 0; i < HDR_LEN; i++) exp_in[i] = 8'(i + 1);
        exp_out = exp_in;
        exp_out[HDR_LEN-1] = 8'hF0;
        proc_hdr_i = exp_out;
        for (int i = 0; i < HDR_LEN + 3; i++) send_byte(8'(i + 1), i == HDR_LEN + 2);
        @(negedge clk);
        n_cmp++;
        if (proc_hdr_o !== exp_in || out_len !== 8'(HDR_LEN) || out_trunc !== 1'b1) begin
            n_err++;
            $display("FAIL trunc_buffer: hdr=%h len=%0d tr=%b required %h / %0d / 1",
                     proc_hdr_o, out_len, out_trunc, exp_in, HDR_LEN);
        end
        tick();
        proc_ready = 1'b1;
        wait_valid(20, cyc);
        proc_ready = 1'b0;
        n_cmp++;
        if (cyc > 20 || out_hdr !== exp_out || out_len !== 8'(HDR_LEN) || out_trunc !== 1'b1) begin
            n_err++;
            $display("FAIL trunc_result: wait=%0d hdr=%h len=%0d tr=%b required <=20 / %h / %0d / 1",
                     cyc, out_hdr, out_len, out_trunc, exp_out, HDR_LEN);
        end
        do_ack();
        n_cmp++;
        if (out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL trunc_clear: out_trunc=%b required 0", out_trunc);
        end
    endtask

    task automatic test_back_pressure();
        hdr_t exp;
        int   cyc;
        int   bad;
        exp = '0; exp[0] = 8'hC1; exp[1] = 8'hC2;
        proc_hdr_i = exp;
        send_byte(8'hC1, 0); send_byte(8'hC2, 1);
        proc_ready = 1'b1;
        wait_valid(20, cyc);
        proc_ready = 1'b0;
        n_cmp++;
        if (cyc > 20) begin
            n_err++;
            $display("FAIL bp_wait: out_valid not seen within 20 cycles");
        end
        in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_hdr !== exp || out_len !== 8'd2 ||
                proc_hdr_o !== exp) begin
                n_err++;
                bad++;
                if (bad < 4)
                    $display("FAIL bp_hold: cycle %0d rdy=%b v=%b hdr=%h len=%0d required 0 / 1 / %h / 2",
                             c, in_ready, out_valid, out_hdr, out_len, exp);
            end
        end
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || proc_hdr_o !== exp) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b v=%b hdr=%h required 1 / 0 / %h", in_ready, out_valid, proc_hdr_o, exp);
        end
    endtask

    task automatic test_async_reset();
        hdr_t exp;
        int   cyc;
        int   starts;
        send_byte(8'hD1, 0); send_byte(8'hD2, 0);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, proc_start, out_valid, out_trunc, err} !== 5'b0 || out_len !== '0 ||
            proc_hdr_o !== '0 || out_hdr !== '0) begin
            n_err++;
            $display("FAIL async_reset: rdy=%b st=%b v=%b len=%0d hdr=%h required all 0",
                     in_ready, proc_start, out_valid, out_len, proc_hdr_o);
        end
        starts = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (proc_start === 1'b1) starts++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (proc_start === 1'b1 || out_valid === 1'b1) starts++;
            tick();
        end
        n_cmp++;
        if (starts !== 0) begin
            n_err++;
            $display("FAIL async_drop: %0d start/valid events after reset required 0", starts);
        end
        exp = '0; exp[0] = 8'h5C;
        proc_hdr_i = exp;
        send_byte(8'h5C, 1);
        @(negedge clk);
        n_cmp++;
        if (proc_start !== 1'b1 || proc_hdr_o !== exp || out_len !== 8'd1) begin
            n_err++;
            $display("FAIL async_next_start: st=%b hdr=%h len=%0d required 1 / %h / 1", proc_start, proc_hdr_o, out_len, exp);
        end
        proc_ready = 1'b1;
        wait_valid(20, cyc);
        proc_ready = 1'b0;
        n_cmp++;
        if (cyc > 20 || out_hdr !== exp || out_len !== 8'd1 || out_trunc !== 1'b0) begin
            n_err++;
            $display("FAIL async_next_result: wait=%0d hdr=%h len=%0d tr=%b required <=20 / %h / 1 / 0",
                     cyc, out_hdr, out_len, out_trunc, exp);
        end
        do_ack();
    endtask

`ifdef HDR_COLLECT_TIMEOUT_EN
    task automatic test_timeout();
        int first_err;
        int pulses;
        int saw_valid;
        first_err = -1; pulses = 0; saw_valid = 0;
        proc_ready = 1'b0;
        send_byte(8'h01, 1);
        for (int c = 1; c <= 20; c++) begin
            tick();
            @(negedge clk);
            if (err === 1'b1) begin
                if (first_err < 0) first_err = c;
                pulses++;
            end
            if (out_valid === 1'b1) saw_valid = 1;
        end
        n_cmp++;
        if (first_err !== 9 || pulses !== 1) begin
            n_err++;
            $display("FAIL timeout_pulse: first=%0d pulses=%0d required 9 / 1", first_err, pulses);
        end
        n_cmp++;
        if (saw_valid !== 0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_state: saw_valid=%0d in_ready=%b required 0 / 1", saw_valid, in_ready);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stale_ready();
        test_trunc();
        test_back_pressure();
        test_async_reset();
`ifdef HDR_COLLECT_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hdr_collector.md
Name: hdr_collector

Overview:
- Ingress stage directly upstream of the per-processor pipeline (parser/matcher/executor wrapper).
- Accepts a packet header as a byte stream and assembles it into the fixed `HDR_MAX_LEN`-byte header array.
- Launches the processor with a one-cycle start pulse, waits for completion, then holds the modified header for the downstream consumer until acknowledged.

Parameters:
- TIMEOUT_CYCLES, 1024, watchdog limit in clock cycles for the processor to complete (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  input byte valid
- in_data_i  in  `BYTE_BUS`  input header byte
- in_last_i  in  1  marks final header byte
- in_ready_o  out  1  collector can accept a byte
- proc_start_o  out  1  one-cycle start pulse to the processor
- proc_hdr_o  out  `BYTE_BUS` x `HDR_MAX_LEN`  assembled header to the processor
- proc_ready_i  in  1  processor done (level; cleared by the processor one cycle after start)
- proc_hdr_i  in  `BYTE_BUS` x `HDR_MAX_LEN`  modified header from the processor
- out_valid_o  out  1  result header available
- out_hdr_o  out  `BYTE_BUS` x `HDR_MAX_LEN`  result header
- out_len_o  out  8  captured byte count, saturated at `HDR_MAX_LEN`
- out_trunc_o  out  1  input exceeded `HDR_MAX_LEN` bytes
- out_ack_i  in  1  consumer accepts the result
- err_o  out  1  one-cycle pulse on processor timeout

Behaviour:
- Reset (async, rst=1): all outputs 0, buffers zeroed, count 0, state IDLE.
- States:
  - IDLE: in_ready_o=1. An accepted byte (valid & ready) zeroes the whole buffer, writes byte 0, sets count=1, and goes to COLLECT. If in_last_i is also 1, it goes to START instead.
  - COLLECT: in_ready_o=1. Each accepted byte is written at index count when count < `HDR_MAX_LEN`; otherwise it is discarded and the trunc flag is set. count saturates at `HDR_MAX_LEN`. An accepted byte with in_last_i goes to START.
  - START: in_ready_o=0. proc_start_o=1 for exactly one cycle, then WAIT with guard=1.
  - WAIT: proc_ready_i is ignored in the first WAIT cycle (guard), because the processor's ready is still stale from the previous packet. After that, proc_ready_i=1 captures proc_hdr_i into out_hdr_o, sets out_valid_o=1, and goes to OUT.
  - OUT: out_valid_o, out_hdr_o, out_len_o and out_trunc_o are held stable. out_ack_i=1 clears out_valid_o and the trunc flag and returns to IDLE. in_ready_o=0 throughout OUT.
- Latency: last byte accepted in cycle t means proc_start_o=1 in cycle t+1. If proc_ready_i rises in cycle u (u ≥ t+3), out_valid_o=1 in cycle u+1.
- proc_hdr_o is driven from the collect buffer. It is stable from START until return to IDLE.
- in_valid_i=0 mid-packet: wait indefinitely in COLLECT; no timeout on input.
- Single-byte packet: out_len_o=1; bytes 1..`HDR_MAX_LEN`-1 read as 0.
- out_ack_i outside OUT is ignored.
- Any state change caused by rst takes effect immediately (asynchronous). An in-flight packet is dropped, and no start pulse or out_valid_o is emitted.

Optional Feature:
- Macro HDR_COLLECT_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without proc_ready_i pulses err_o for one cycle and returns to IDLE. The packet is dropped and out_valid_o is not asserted.
  - The counter clears on entering WAIT.
- Undefined: no counter; WAIT lasts until proc_ready_i; err_o tied 0.

Decomposition:
- Shared package:
  - state enum typedef (IDLE, COLLECT, START, WAIT, OUT);
  - header array typedef (`BYTE_BUS` x `HDR_MAX_LEN`);
  - length width constant.
- Existing `TRUE`/`FALSE`, `BYTE_BUS`, `HDR_MAX_LEN` come from def.svh.
- Natural sub-module: hdr_collect_buf, holding the byte buffer, the write-index/saturating count and the trunc flag. The top holds the FSM, processor handshake and output register.

Test Plan:
- 4-byte packet 0x11,0x22,0x33,0x44 (last on 0x44), proc model returns ready 5 cycles after start with byte0 changed to 0xAA → one proc_start_o pulse; out_hdr_o[0..3]=AA,22,33,44, rest 0, out_len_o=4, out_trunc_o=0.
- Stale proc_ready_i=1 held from prior packet, new 1-byte packet → ready ignored in guard cycle, no capture until the model drops then reasserts ready.
- `HDR_MAX_LEN`+3 byte packet → out_len_o=`HDR_MAX_LEN`, out_trunc_o=1, last 3 bytes absent from proc_hdr_o.
- Consumer withholds out_ack_i for 20 cycles while in_valid_i=1 → in_ready_o=0 throughout, outputs stable; ack → in_ready_o=1 next cycle.
- rst pulsed mid-COLLECT after 2 bytes → all outputs 0 immediately; next 1-byte packet yields out_len_o=1 with clean buffer.
- With HDR_COLLECT_TIMEOUT_EN and TIMEOUT_CYCLES=8, proc never ready → err_o single pulse 8 cycles into WAIT, out_valid_o never 1, in_ready_o=1 afterwards.
